// File: rtl/keypad_pkg.sv
// Shared key codes, key-map decode and debounce state type for the keypad scanner.
package keypad_pkg;

    localparam logic [4:0] KEY_NONE = 5'b00000;
    localparam logic [4:0] KEY_1    = 5'b00001;
    localparam logic [4:0] KEY_2    = 5'b00010;
    localparam logic [4:0] KEY_3    = 5'b00011;
    localparam logic [4:0] KEY_4    = 5'b00100;
    localparam logic [4:0] KEY_5    = 5'b00101;
    localparam logic [4:0] KEY_6    = 5'b00110;
    localparam logic [4:0] KEY_7    = 5'b00111;
    localparam logic [4:0] KEY_8    = 5'b01000;
    localparam logic [4:0] KEY_9    = 5'b01001;
    localparam logic [4:0] KEY_A    = 5'b01010;
    localparam logic [4:0] KEY_B    = 5'b01011;
    localparam logic [4:0] KEY_C    = 5'b01100;
    localparam logic [4:0] KEY_D    = 5'b01101;
    localparam logic [4:0] KEY_STAR = 5'b10000;
    localparam logic [4:0] KEY_0    = 5'b10001;
    localparam logic [4:0] KEY_HASH = 5'b10010;

    typedef enum logic [1:0] {
        ST_NONE,
        ST_PRESS_PEND,
        ST_HELD,
        ST_RELEASE_PEND
    } db_state_t;

    // Key-map index is row*4+col.
    function automatic logic [4:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:    return KEY_1;
            4'd1:    return KEY_2;
            4'd2:    return KEY_3;
            4'd3:    return KEY_A;
            4'd4:    return KEY_4;
            4'd5:    return KEY_5;
            4'd6:    return KEY_6;
            4'd7:    return KEY_B;
            4'd8:    return KEY_7;
            4'd9:    return KEY_8;
            4'd10:   return KEY_9;
            4'd11:   return KEY_C;
            4'd12:   return KEY_STAR;
            4'd13:   return KEY_0;
            4'd14:   return KEY_HASH;
            default: return KEY_D;
        endcase
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM: qualifies per-scan candidate codes into a steady key code plus press strobe.
//
// state           | meaning
// ST_NONE         | no key reported, waiting for a nonzero candidate
// ST_PRESS_PEND   | same nonzero candidate being counted toward a press
// ST_HELD         | data shows a key, candidate still matches it
// ST_RELEASE_PEND | candidate differs from data, counting toward release
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_done,
    input  logic [4:0] candidate,
    output logic [4:0] data,
    output logic       key_strobe
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam bit ONE_SCAN = (DEBOUNCE_SCANS == 1);

    db_state_t     state;
    logic [4:0]    pend_code;
    logic [CW-1:0] stable_cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        key_strobe <= 1'b0;
        if (rst) begin
            state      <= ST_NONE;
            pend_code  <= KEY_NONE;
            stable_cnt <= '0;
            data       <= KEY_NONE;
        end else if (scan_done) begin
            case (state)
                ST_NONE: begin
                    if (candidate != KEY_NONE) begin
                        pend_code <= candidate;
                        if (ONE_SCAN) begin
                            data       <= candidate;
                            key_strobe <= 1'b1;
                            stable_cnt <= '0;
                            state      <= ST_HELD;
                        end else begin
                            stable_cnt <= CNT_ONE;
                            state      <= ST_PRESS_PEND;
                        end
                    end
                end
                ST_PRESS_PEND: begin
                    if (candidate == KEY_NONE) begin
                        stable_cnt <= '0;
                        state      <= ST_NONE;
                    end else if (candidate == pend_code) begin
                        if (cnt_inc == CNT_MAX) begin
                            data       <= pend_code;
                            key_strobe <= 1'b1;
                            stable_cnt <= '0;
                            state      <= ST_HELD;
                        end else begin
                            stable_cnt <= cnt_inc;
                        end
                    end else begin
                        pend_code <= candidate;
                        if (ONE_SCAN) begin
                            data       <= candidate;
                            key_strobe <= 1'b1;
                            stable_cnt <= '0;
                            state      <= ST_HELD;
                        end else begin
                            stable_cnt <= CNT_ONE;
                        end
                    end
                end
                ST_HELD: begin
                    if (candidate != data) begin
                        if (ONE_SCAN) begin
                            data       <= KEY_NONE;
                            stable_cnt <= '0;
                            state      <= ST_NONE;
                        end else begin
                            stable_cnt <= CNT_ONE;
                            state      <= ST_RELEASE_PEND;
                        end
                    end
                end
                ST_RELEASE_PEND: begin
                    if (candidate == data) begin
                        stable_cnt <= '0;
                        state      <= ST_HELD;
                    end else if (cnt_inc == CNT_MAX) begin
                        // Release always lands on KEY_NONE so a direct key change shows a gap.
                        data       <= KEY_NONE;
                        stable_cnt <= '0;
                        state      <= ST_NONE;
                    end else begin
                        stable_cnt <= cnt_inc;
                    end
                end
                default: state <= ST_NONE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with key map, one-hot decode and debounced key code output.
// Optional two-flop row synchronizer enabled by defining KEYPAD_ROW_SYNC_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12500,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] data,
    output logic       key_strobe
);

    logic [3:0] row_s;

`ifdef KEYPAD_ROW_SYNC_EN
    localparam int LEAD = 2;
    logic [3:0] row_q1;
    logic [3:0] row_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q1 <= 4'hF;
            row_q2 <= 4'hF;
        end else begin
            row_q1 <= row;
            row_q2 <= row_q1;
        end
    end

    assign row_s = row_q2;
`else
    localparam int LEAD = 0;
    assign row_s = row;
`endif

    localparam int DW = $clog2(SCAN_DIV + LEAD + 1);
    localparam logic [DW-1:0] TERM       = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] TERM_FIRST = DW'(SCAN_DIV - 1 + LEAD);

    logic [DW-1:0] div_cnt;
    logic          first_period;
    logic [1:0]    col_idx;
    logic [15:0]   key_map;
    logic [15:0]   map_next;
    logic          sample;
    logic          scan_done;
    logic [4:0]    candidate;

    // Stretching only the first period after reset keeps every later column at SCAN_DIV
    // while the synchronizer delay lines the sample up with the column being driven.
    assign sample    = (div_cnt == (first_period ? TERM_FIRST : TERM));
    assign scan_done = sample && (col_idx == 2'd3);

    always_comb begin
        map_next = key_map;
        if (sample) begin
            for (int r = 0; r < 4; r++) begin
                map_next[r*4 + int'(col_idx)] = ~row_s[r];
            end
        end
    end

    always_comb begin
        candidate = KEY_NONE;
        if ($countones(map_next) == 1) begin
            for (int i = 0; i < 16; i++) begin
                if (map_next[i]) candidate = key_code(4'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt      <= '0;
            first_period <= 1'b1;
            col_idx      <= 2'd0;
            col          <= 4'b1110;
            key_map      <= '0;
        end else begin
            key_map <= map_next;
            if (sample) begin
                div_cnt      <= '0;
                first_period <= 1'b0;
                col_idx      <= col_idx + 2'd1;
                col          <= {col[2:0], col[3]};
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .scan_done  (scan_done),
        .candidate  (candidate),
        .data       (data),
        .key_strobe (key_strobe)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and random scan-level stimulus against a run-length model of the debounce rules.
module tb_keypad_scanner;

    localparam int SD   = 4;
    localparam int DB   = 3;
    localparam int SCAN = 4 * SD;

    localparam logic [15:0] K1    = 16'h0001;
    localparam logic [15:0] KA    = 16'h0008;
    localparam logic [15:0] K5    = 16'h0020;
    localparam logic [15:0] K7    = 16'h0100;
    localparam logic [15:0] K0    = 16'h2000;
    localparam logic [15:0] KHASH = 16'h4000;
    localparam logic [15:0] KD    = 16'h8000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [4:0] data;
    logic       key_strobe;
    logic [15:0] pressed;

    int total = 0;
    int bad = 0;
    int strobes = 0;

    logic [4:0] m_data;
    logic [4:0] hist[$];
    logic [4:0] code_tab [0:15] = '{5'd1, 5'd2, 5'd3, 5'd10,
                                    5'd4, 5'd5, 5'd6, 5'd11,
                                    5'd7, 5'd8, 5'd9, 5'd12,
                                    5'd16, 5'd17, 5'd18, 5'd13};

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .data       (data),
        .key_strobe (key_strobe)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) shorts row r to column c while that column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(pressed[r*4 +: 4] & ~col);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] cand_of(input logic [15:0] k);
        if ($countones(k) != 1) return 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) return code_tab[i];
        end
        return 5'd0;
    endfunction

    task automatic model_reset();
        m_data = 5'd0;
        hist.delete();
    endtask

    // One full scan with a fixed key set, then compare against the run-length model.
    task automatic do_scan(input logic [15:0] keys);
        int col_err, extra, moved;
        logic [3:0] exp_col;
        logic [4:0] cand;
        logic exp_strobe;
        bit all_eq, all_ne;
        col_err = 0;
        extra = 0;
        moved = 0;
        pressed = keys;
        for (int i = 0; i < SCAN; i++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << (((i + 1) / SD) % 4));
            if (col !== exp_col) col_err++;
            if (key_strobe === 1'b1) strobes++;
            if (i < SCAN - 1) begin
                if (key_strobe !== 1'b0) extra++;
                if (data !== m_data) moved++;
            end
        end
        cand = cand_of(keys);
        hist.push_back(cand);
        exp_strobe = 1'b0;
        if (hist.size() >= DB) begin
            all_eq = 1;
            all_ne = 1;
            for (int j = hist.size() - DB; j < hist.size(); j++) begin
                if (hist[j] != cand) all_eq = 0;
                if (hist[j] == m_data) all_ne = 0;
            end
            if (m_data == 5'd0 && cand != 5'd0 && all_eq) begin
                m_data = cand;
                exp_strobe = 1'b1;
                hist.delete();
            end else if (m_data != 5'd0 && all_ne) begin
                m_data = 5'd0;
                hist.delete();
            end
        end
        check("col_rotation", col_err, 0);
        check("strobe_midscan", extra, 0);
        check("data_steady", moved, 0);
        check("data", data, m_data);
        check("strobe", key_strobe, exp_strobe);
    endtask

    initial begin
        int s0;
        int pick;
        logic [15:0] keys;

        rst = 1'b1;
        pressed = 16'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_col", col, 4'b1110);
        check("reset_data", data, 5'd0);
        check("reset_strobe", key_strobe, 1'b0);
        rst = 1'b0;
        do_scan(16'h0);
        do_scan(16'h0);

        // stable press and release of "5"
        s0 = strobes;
        for (int k = 1; k <= 10; k++) begin
            do_scan(K5);
            if (k == 2) check("press5_early", data, 5'd0);
            if (k == 3) check("press5_valid", data, 5'b00101);
        end
        for (int k = 1; k <= 4; k++) begin
            do_scan(16'h0);
            if (k == 2) check("release5_early", data, 5'b00101);
            if (k == 3) check("release5_done", data, 5'd0);
        end
        check("press5_strobes", strobes - s0, 1);

        // bouncing "#"
        do_scan(KHASH);
        do_scan(16'h0);
        do_scan(KHASH);
        do_scan(16'h0);
        do_scan(KHASH);
        do_scan(KHASH);
        check("bounce_wait", data, 5'd0);
        do_scan(KHASH);
        check("bounce_hash", data, 5'b10010);
        for (int k = 0; k < 3; k++) do_scan(16'h0);

        // multi-press "1"+"A"
        for (int k = 0; k < 5; k++) do_scan(K1 | KA);
        check("multi_none", data, 5'd0);
        for (int k = 0; k < 3; k++) do_scan(K1);
        check("multi_release_a", data, 5'b00001);
        for (int k = 0; k < 3; k++) do_scan(16'h0);

        // direct change "0" -> "D"
        s0 = strobes;
        for (int k = 0; k < 3; k++) do_scan(K0);
        check("direct_zero", data, 5'b10001);
        for (int k = 0; k < 3; k++) do_scan(KD);
        check("direct_gap", data, 5'd0);
        for (int k = 0; k < 3; k++) do_scan(KD);
        check("direct_d", data, 5'b01101);
        check("direct_strobes", strobes - s0, 2);
        for (int k = 0; k < 3; k++) do_scan(16'h0);

        // reset while "7" is held
        for (int k = 0; k < 3; k++) do_scan(K7);
        check("held_7", data, 5'b00111);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_data", data, 5'd0);
        check("midreset_col", col, 4'b1110);
        check("midreset_strobe", key_strobe, 1'b0);
        rst = 1'b0;
        model_reset();
        do_scan(K7);
        do_scan(K7);
        check("midreset_wait", data, 5'd0);
        do_scan(K7);
        check("midreset_7", data, 5'b00111);

        // random key activity
        keys = K7;
        for (int k = 0; k < 40; k++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 40) begin
                keys = keys;
            end else if (pick < 70) begin
                keys = 16'h1 << $urandom_range(0, 15);
            end else if (pick < 85) begin
                keys = 16'h0;
            end else begin
                keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            end
            do_scan(keys);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
